pc_gen_bp: RTL and testbench

//  Fetch-stage PC generator, parametrised successor of the single-cycle PC mux. Holds the fetch PC and

---
 rtl/pc_gen_pkg.sv | 28 ++
 rtl/pc_gen_bp_btb_dir.sv | 70 +++++++
 rtl/pc_gen_bp.sv | 85 ++++++++
 tb/tb_pc_gen_bp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types, defaults and width helpers for the fetch PC generator
package pc_gen_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Saturating 2-bit counter step toward the resolved direction
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == ST) ? ST : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_gen_bp_btb_dir.sv
// rtl/pc_gen_bp_btb_dir.sv - direct-mapped BTB with 2-bit counters, combinational read, synchronous write
module btb_dir
  import pc_gen_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_valid,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(XLEN, ENTRIES);

  logic            valid   [ENTRIES];
  logic [TW-1:0]   tags    [ENTRIES];
  logic [XLEN-1:0] targets [ENTRIES];
  ctr_t            ctrs    [ENTRIES];

  logic [IW-1:0] rd_idx, wr_idx;
  logic [TW-1:0] rd_tag, wr_tag;
  logic          rd_hit, wr_hit;

  // Instruction byte offset never selects an entry
  logic unused_low;
  assign unused_low = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_idx = rd_pc[IW+1:2];
  assign rd_tag = rd_pc[XLEN-1:IW+2];
  assign wr_idx = wr_pc[IW+1:2];
  assign wr_tag = wr_pc[XLEN-1:IW+2];

  // Lookup reads pre-write contents; a same-cycle update is not bypassed
  always_comb begin
    rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    rd_taken  = rd_hit && (ctrs[rd_idx] inside {WT, ST});
    rd_target = targets[rd_idx];
    wr_hit    = valid[wr_idx] && (tags[wr_idx] == wr_tag);
  end

  // Training: strengthen/weaken on tag match, allocate weak-taken on taken miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= SNT;
      end
    end else if (wr_valid) begin
      if (wr_hit) begin
        ctrs[wr_idx] <= ctr_next(ctrs[wr_idx], wr_taken);
        if (wr_taken) targets[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid[wr_idx]   <= 1'b1;
        tags[wr_idx]    <= wr_tag;
        targets[wr_idx] <= wr_target;
        ctrs[wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// rtl/pc_gen_bp.sv - fetch PC register with BTB-driven next-PC prediction and EX redirect
module pc_gen_bp
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter int              PC_STEP     = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q, pc_d, pred_target_q, pred_target_d;
  logic            pred_taken_q, pred_taken_d;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  btb_dir #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (pc_q),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_valid  (upd_valid_i),
    .wr_pc     (upd_pc_i),
    .wr_taken  (upd_taken_i),
    .wr_target (upd_target_i)
  );

  // Next-PC priority: redirect beats stall so a flush is never dropped
  always_comb begin
    pc_d          = pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (redirect_i) begin
      pc_d          = redirect_pc_i & ALIGN_MASK;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
    end else if (!pc_stall_i) begin
      if (btb_taken) begin
        pc_d          = btb_target;
        pred_taken_d  = 1'b1;
        pred_target_d = btb_target;
      end else begin
        pc_d          = pc_q + XLEN'(PC_STEP);
        pred_taken_d  = 1'b0;
        pred_target_d = '0;
      end
    end
  end

  // PC and the prediction that produced it are registered together for EX comparison
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VEC;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pc_o          = pc_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb/tb_pc_gen_bp.sv - self-checking bench for pc_gen_bp with a behavioural next-PC/BTB model
module tb_pc_gen_bp;

  localparam int          N  = 16;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0, reset = 1'b0;
  logic        pc_stall_i = 1'b0, redirect_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, upd_pc_i = '0, upd_target_i = '0;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o;

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_pc, m_ptgt;
  logic        m_pt;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  pc_gen_bp #(.XLEN(32), .RESET_VEC(RV), .BTB_ENTRIES(N), .PC_STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_stall_i    (pc_stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .pc_o          (pc_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV; m_pt = 1'b0; m_ptgt = '0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
  endtask

  // One clock of the reference: next PC from old table, then training
  task automatic model_step();
    logic [31:0] p = m_pc;
    int          i = int'((p / 4) % N);
    bit          pred = m_valid[i] && (m_tag[i] == p / (4 * N)) && (m_ctr[i] >= 2);
    logic [31:0] t;
    int          j;
    if (redirect_i) begin
      m_pc = redirect_pc_i - (redirect_pc_i % 4); m_pt = 1'b0; m_ptgt = '0;
    end else if (!pc_stall_i) begin
      if (pred) begin
        m_pc = m_tgt[i]; m_pt = 1'b1; m_ptgt = m_tgt[i];
      end else begin
        m_pc = p + 32'd4; m_pt = 1'b0; m_ptgt = '0;
      end
    end
    if (upd_valid_i) begin
      j = int'((upd_pc_i / 4) % N);
      t = upd_pc_i / (4 * N);
      if (m_valid[j] && m_tag[j] == t) begin
        if (upd_taken_i) begin
          if (m_ctr[j] < 3) m_ctr[j]++;
          m_tgt[j] = upd_target_i;
        end else if (m_ctr[j] > 0) m_ctr[j]--;
      end else if (upd_taken_i) begin
        m_valid[j] = 1'b1; m_tag[j] = t; m_tgt[j] = upd_target_i; m_ctr[j] = 2;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    pc_stall_i = 1'b0; redirect_i = 1'b0; upd_valid_i = 1'b0; upd_taken_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (pc_o !== 32'h100) begin errs++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h100); end
    vecs++; if (pred_taken_o !== 1'b0) begin errs++; $display("FAIL reset_pt: got %b expected 0", pred_taken_o); end
    vecs++; if (pred_target_o !== 32'h0) begin errs++; $display("FAIL reset_ptgt: got %h expected 0", pred_target_o); end
    @(negedge clk); reset = 1'b0; model_reset();
    cycle();
    vecs++; if (pc_o !== 32'h104) begin errs++; $display("FAIL seq_1: got %h expected %h", pc_o, 32'h104); end
    cycle();
    vecs++; if (pc_o !== 32'h108) begin errs++; $display("FAIL seq_2: got %h expected %h", pc_o, 32'h108); end
    vecs++; if (pred_taken_o !== 1'b0) begin errs++; $display("FAIL seq_pt: got %b expected 0", pred_taken_o); end
  endtask

  task automatic test_train_taken();
    idle(); upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1; upd_target_i = 32'h200;
    cycle();
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle();
    idle();
    vecs++; if (pc_o !== 32'h100) begin errs++; $display("FAIL tk_redir: got %h expected %h", pc_o, 32'h100); end
    cycle();
    vecs++; if (pc_o !== 32'h104 || pred_taken_o !== 1'b0) begin errs++; $display("FAIL tk_seq: got %h/%b expected 104/0", pc_o, pred_taken_o); end
    cycle();
    vecs++; if (pc_o !== 32'h200) begin errs++; $display("FAIL tk_jump: got %h expected %h", pc_o, 32'h200); end
    vecs++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin errs++; $display("FAIL tk_pred: got %b/%h expected 1/200", pred_taken_o, pred_target_o); end
  endtask

  task automatic test_train_not_taken();
    idle(); upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b0;
    cycle(); cycle();
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle();
    idle();
    cycle(); cycle();
    vecs++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin errs++; $display("FAIL ntk_fall: got %h/%b expected 108/0", pc_o, pred_taken_o); end
  endtask

  task automatic test_stall_redirect();
    idle(); pc_stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h3FE;
    cycle();
    vecs++; if (pc_o !== 32'h3FC) begin errs++; $display("FAIL stall_redir: got %h expected %h", pc_o, 32'h3FC); end
    redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      vecs++; if (pc_o !== 32'h3FC) begin errs++; $display("FAIL stall_hold%0d: got %h expected %h", k, pc_o, 32'h3FC); end
    end
    idle();
  endtask

  task automatic test_alias();
    idle(); upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1; upd_target_i = 32'h200;
    cycle();
    upd_pc_i = 32'h144; upd_target_i = 32'h300;
    cycle();
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle();
    idle(); cycle(); cycle();
    vecs++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin errs++; $display("FAIL alias_old: got %h/%b expected 108/0", pc_o, pred_taken_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h140;
    cycle();
    idle(); cycle(); cycle();
    vecs++; if (pc_o !== 32'h300 || pred_taken_o !== 1'b1) begin errs++; $display("FAIL alias_new: got %h/%b expected 300/1", pc_o, pred_taken_o); end
  endtask

  task automatic test_async_reset();
    idle(); upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1; upd_target_i = 32'h200;
    cycle();
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'h500;
    cycle();
    idle();
    vecs++; if (pc_o !== 32'h500) begin errs++; $display("FAIL ar_pre: got %h expected %h", pc_o, 32'h500); end
    #2 reset = 1'b1;
    #1;
    vecs++; if (pc_o !== RV || pred_taken_o !== 1'b0) begin errs++; $display("FAIL ar_now: got %h/%b expected %h/0", pc_o, pred_taken_o, RV); end
    upd_valid_i = 1'b1; upd_pc_i = 32'h144; upd_taken_i = 1'b1; upd_target_i = 32'h300;
    @(posedge clk); #1;
    idle();
    @(negedge clk); reset = 1'b0; model_reset();
    cycle(); cycle();
    vecs++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin errs++; $display("FAIL ar_clr104: got %h/%b expected 108/0", pc_o, pred_taken_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h140;
    cycle();
    idle(); cycle(); cycle();
    vecs++; if (pc_o !== 32'h148 || pred_taken_o !== 1'b0) begin errs++; $display("FAIL ar_abort: got %h/%b expected 148/0", pc_o, pred_taken_o); end
  endtask

  task automatic test_wrap();
    idle(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    idle(); cycle();
    vecs++; if (pc_o !== 32'h0) begin errs++; $display("FAIL wrap: got %h expected 0", pc_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      pc_stall_i    = ($urandom_range(4) == 0);
      redirect_i    = ($urandom_range(9) == 0);
      redirect_pc_i = 32'h100 + 32'($urandom_range(63)) * 4 + 32'($urandom_range(3));
      upd_valid_i   = ($urandom_range(4) < 2);
      upd_pc_i      = 32'h100 + 32'($urandom_range(63)) * 4;
      upd_taken_i   = ($urandom_range(4) < 3);
      upd_target_i  = 32'h100 + 32'($urandom_range(63)) * 4;
      cycle();
      vecs++; if (pc_o !== m_pc) begin errs++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc_o, m_pc); end
      vecs++; if (pred_taken_o !== m_pt) begin errs++; $display("FAIL rnd_pt[%0d]: got %b expected %b", n, pred_taken_o, m_pt); end
      if (m_pt) begin
        vecs++; if (pred_target_o !== m_ptgt) begin errs++; $display("FAIL rnd_ptgt[%0d]: got %h expected %h", n, pred_target_o, m_ptgt); end
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_stall_redirect();
    test_alias();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
